// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl -- sequencer for one butterfly stage of the pipelined NTT.
//
// Accepts a frame of N = 2**LOG_N coefficients and presents them to the
// butterfly PE one per accepted sample, together with the twiddle-ROM address,
// the sel_a / sel_b path selects and a valid flag aligned to the PE output.
// Bubbles (in_valid low while running) propagate through to out_valid.
// After the N-th sample the PE pipeline is drained and done pulses once.
//
// Optional build macro: NTT_STAGE_CTRL_STALL_CNT_EN adds the 16-bit
// stall_cnt output (RUN cycles with in_valid low, saturating).
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   start      one-cycle frame-start request (honoured only in IDLE)
//   in_valid   input sample valid
//   in_data    input coefficient
//   in_ready   stage accepts a sample this cycle (RUN only)
//   pe_data    to PE data_i
//   pe_sel_a   to PE sel_a (1 = odd half of the butterfly group)
//   pe_sel_b   to PE sel_b (pe_sel_a delayed PE_LAT cycles)
//   tw_addr    twiddle ROM address (ROM read is registered, 1 cycle)
//   out_valid  PE ntt_o carries a valid result this cycle
//   busy       FSM not in IDLE
//   done       one-cycle pulse, frame fully drained
//   stall_cnt  (optional) count of RUN cycles with in_valid low
//
// state | meaning
// IDLE  | waiting for start; delay lines keep shifting
// RUN   | accepting samples, in_ready=1
// DRAIN | all N samples taken, waiting PE_LAT+1 cycles for the last result
// DONE  | single cycle, done=1

`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

module ntt_stage_ctrl #(
  parameter int DATA_W   = `DATA_SIZE_ARB,
  parameter int LOG_N    = 10,
  parameter int STAGE    = 0,
  parameter int MULT_LAT = 12,
  parameter int PE_LAT   = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] pe_data,
  output logic              pe_sel_a,
  output logic              pe_sel_b,
  output logic [LOG_N-2:0]  tw_addr,
  output logic              out_valid,
  output logic              busy,
  output logic              done
`ifdef NTT_STAGE_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int DRAIN_W  = $clog2(PE_LAT + 1);
  localparam int TW_SHIFT = LOG_N - 1 - STAGE;
  localparam logic [LOG_N-1:0]   HALF_MASK = LOG_N'((1 << STAGE) - 1);
  localparam logic [LOG_N-1:0]   IDX_LAST  = '1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PE_LAT);

  if (PE_LAT != MULT_LAT + 2) begin : g_bad_lat
    $error("ntt_stage_ctrl: PE_LAT must equal MULT_LAT+2");
  end
  if (STAGE < 0 || STAGE >= LOG_N) begin : g_bad_stage
    $error("ntt_stage_ctrl: STAGE out of range");
  end
  if (PE_LAT < 2) begin : g_bad_pe_lat
    $error("ntt_stage_ctrl: PE_LAT must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [LOG_N-1:0]   idx;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               accept;
  logic               v1;
  logic [PE_LAT-1:0]  v_sr;
  logic [PE_LAT-1:0]  sb_sr;
  logic [LOG_N-2:0]   tw_hold;
  logic [LOG_N-2:0]   tw_calc;

  assign in_ready = (state == S_RUN);
  assign accept   = in_valid & in_ready;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  // (idx mod HALF) placed in the top bits: stride of N/(2*HALF) through the ROM.
  // The mask clears idx[LOG_N-1], so the narrowing cast loses nothing.
  assign tw_calc = ((LOG_N-1)'(idx & HALF_MASK)) << TW_SHIFT;
  assign tw_addr = accept ? tw_calc : tw_hold;

  assign out_valid = v_sr[PE_LAT-1];
  assign pe_sel_b  = sb_sr[PE_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            idx   <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            idx <= idx + LOG_N'(1);
            if (idx == IDX_LAST) begin
              state     <= S_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath register stage lines up with the ROM's registered read; the
  // delay lines free-run in every state so a draining frame always completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pe_data  <= '0;
      pe_sel_a <= 1'b0;
      v1       <= 1'b0;
      v_sr     <= '0;
      sb_sr    <= '0;
      tw_hold  <= '0;
    end else begin
      if (accept) begin
        pe_data <= in_data;
      end
      pe_sel_a <= accept & idx[STAGE];
      v1       <= accept;
      v_sr     <= {v_sr[PE_LAT-2:0], v1};
      sb_sr    <= {sb_sr[PE_LAT-2:0], pe_sel_a};
      tw_hold  <= tw_addr;
    end
  end

`ifdef NTT_STAGE_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == S_RUN && !in_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Testbench for ntt_stage_ctrl: two instances (STAGE=1 and STAGE=0, LOG_N=4,
// PE_LAT=14) share one random stimulus stream. A transaction-level model
// schedules, for each accepted sample, the expected sel_a / out_valid / sel_b
// events at absolute future cycles, and the done pulse after the last sample.
module tb_ntt_stage_ctrl;
  localparam int DATA_W   = 16;
  localparam int LOG_N    = 4;
  localparam int N        = 16;
  localparam int MULT_LAT = 12;
  localparam int PE_LAT   = 14;
  localparam int MAXC     = 64;

  logic              clk;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;

  logic              in_ready1, pe_sel_a1, pe_sel_b1, out_valid1, busy1, done1;
  logic [DATA_W-1:0] pe_data1;
  logic [LOG_N-2:0]  tw_addr1;
  logic              in_ready0, pe_sel_a0, pe_sel_b0, out_valid0, busy0, done0;
  logic [DATA_W-1:0] pe_data0;
  logic [LOG_N-2:0]  tw_addr0;
`ifdef NTT_STAGE_CTRL_STALL_CNT_EN
  logic [15:0]       stall_cnt1, stall_cnt0;
`endif

  ntt_stage_ctrl #(.DATA_W(DATA_W), .LOG_N(LOG_N), .STAGE(1), .MULT_LAT(MULT_LAT), .PE_LAT(PE_LAT)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .pe_data(pe_data1), .pe_sel_a(pe_sel_a1), .pe_sel_b(pe_sel_b1),
    .tw_addr(tw_addr1), .out_valid(out_valid1), .busy(busy1), .done(done1)
`ifdef NTT_STAGE_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  ntt_stage_ctrl #(.DATA_W(DATA_W), .LOG_N(LOG_N), .STAGE(0), .MULT_LAT(MULT_LAT), .PE_LAT(PE_LAT)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .pe_data(pe_data0), .pe_sel_a(pe_sel_a0), .pe_sel_b(pe_sel_b0),
    .tw_addr(tw_addr0), .out_valid(out_valid0), .busy(busy0), .done(done0)
`ifdef NTT_STAGE_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt0)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int cyc;

  // reference model
  bit              m_run;
  int              m_cnt;
  int              m_done_cyc;
  logic [DATA_W-1:0] m_data;
  int              m_tw1, m_tw0;
  int              m_stall;
  bit              sa_v[MAXC];
  int              sa_idx[MAXC];
  bit              ov_v[MAXC];
  int              ov_idx[MAXC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int tw_of(input int idx, input int stage);
    int half;
    half = 1 << stage;
    return (idx % half) * ((N / 2) / half);
  endfunction

  function automatic int sel_of(input int idx, input int stage);
    return (idx / (1 << stage)) % 2;
  endfunction

  task automatic model_clear();
    m_run = 0; m_cnt = 0; m_done_cyc = -1; m_data = '0;
    m_tw1 = 0; m_tw0 = 0; m_stall = 0;
    for (int i = 0; i < MAXC; i++) begin
      sa_v[i] = 0; sa_idx[i] = 0; ov_v[i] = 0; ov_idx[i] = 0;
    end
  endtask

  task automatic check_all_zero();
    check_eq("rst_in_ready", 32'(in_ready1), 0);
    check_eq("rst_pe_data", 32'(pe_data1), 0);
    check_eq("rst_pe_sel_a", 32'(pe_sel_a1), 0);
    check_eq("rst_pe_sel_b", 32'(pe_sel_b1), 0);
    check_eq("rst_tw_addr", 32'(tw_addr1), 0);
    check_eq("rst_out_valid", 32'(out_valid1), 0);
    check_eq("rst_busy", 32'(busy1), 0);
    check_eq("rst_done", 32'(done1), 0);
    check_eq("rst_out_valid_s0", 32'(out_valid0), 0);
    check_eq("rst_busy_s0", 32'(busy0), 0);
    check_eq("rst_done_s0", 32'(done0), 0);
`ifdef NTT_STAGE_CTRL_STALL_CNT_EN
    check_eq("rst_stall_cnt", 32'(stall_cnt1), 0);
`endif
  endtask

  // Called right after a falling edge; holds reset for ncyc cycles with
  // random inputs and releases it on a falling edge.
  task automatic do_reset(input int ncyc);
    reset = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      start    = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DATA_W'($urandom);
      #1;
      check_all_zero();
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    model_clear();
  endtask

  task automatic step(input bit st, input bit vld, input logic [DATA_W-1:0] dat);
    int s, s1, sl;
    bit acc, bsy;
    start = st; in_valid = vld; in_data = dat;
    #1;
    s   = cyc % MAXC;
    acc = m_run && vld;
    bsy = m_run || (m_done_cyc >= cyc);

    check_eq("in_ready", 32'(in_ready1), 32'(m_run));
    check_eq("in_ready_s0", 32'(in_ready0), 32'(m_run));
    check_eq("busy", 32'(busy1), 32'(bsy));
    check_eq("busy_s0", 32'(busy0), 32'(bsy));
    check_eq("done", 32'(done1), 32'(cyc == m_done_cyc));
    check_eq("done_s0", 32'(done0), 32'(cyc == m_done_cyc));
    check_eq("out_valid", 32'(out_valid1), 32'(ov_v[s]));
    check_eq("out_valid_s0", 32'(out_valid0), 32'(ov_v[s]));
    check_eq("pe_data", 32'(pe_data1), 32'(m_data));
    check_eq("pe_data_s0", 32'(pe_data0), 32'(m_data));
    check_eq("pe_sel_a", 32'(pe_sel_a1), sa_v[s] ? sel_of(sa_idx[s], 1) : 0);
    check_eq("pe_sel_a_s0", 32'(pe_sel_a0), sa_v[s] ? sel_of(sa_idx[s], 0) : 0);
    check_eq("pe_sel_b", 32'(pe_sel_b1), ov_v[s] ? sel_of(ov_idx[s], 1) : 0);
    check_eq("pe_sel_b_s0", 32'(pe_sel_b0), ov_v[s] ? sel_of(ov_idx[s], 0) : 0);
    check_eq("tw_addr", 32'(tw_addr1), acc ? tw_of(m_cnt, 1) : m_tw1);
    check_eq("tw_addr_s0", 32'(tw_addr0), acc ? tw_of(m_cnt, 0) : m_tw0);
`ifdef NTT_STAGE_CTRL_STALL_CNT_EN
    check_eq("stall_cnt", 32'(stall_cnt1), m_stall);
    check_eq("stall_cnt_s0", 32'(stall_cnt0), m_stall);
`endif

    sa_v[s] = 0;
    ov_v[s] = 0;
    if (acc) begin
      s1 = (cyc + 1) % MAXC;
      sl = (cyc + 1 + PE_LAT) % MAXC;
      sa_v[s1] = 1; sa_idx[s1] = m_cnt;
      ov_v[sl] = 1; ov_idx[sl] = m_cnt;
      m_data = dat;
      m_tw1 = tw_of(m_cnt, 1);
      m_tw0 = tw_of(m_cnt, 0);
      m_cnt++;
      if (m_cnt == N) begin
        m_run = 0;
        m_done_cyc = cyc + PE_LAT + 2;
      end
    end else if (m_run && !vld && m_stall < 65535) begin
      m_stall++;
    end
    if (st && !bsy) begin
      m_run = 1; m_cnt = 0; m_stall = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  // gap_kind: 0 gapless with data 0,1,2..; 1 in_valid low every 3rd cycle;
  // 2 random valid. start_always holds start high through RUN/DRAIN/DONE.
  // abort_after > 0 asserts reset that many cycles into the frame.
  task automatic run_frame(input int gap_kind, input bit start_always, input int abort_after);
    int k;
    bit vld, fin;
    logic [DATA_W-1:0] d;
    step(1'b1, 1'($urandom_range(0, 1)), DATA_W'($urandom));
    k = 0;
    while (1) begin
      case (gap_kind)
        0:       vld = 1'b1;
        1:       vld = (k % 3) != 2;
        default: vld = $urandom_range(0, 3) != 0;
      endcase
      d   = (gap_kind == 0) ? DATA_W'(k) : DATA_W'($urandom);
      fin = (cyc == m_done_cyc);
      step(start_always, vld, d);
      k++;
      if (fin) break;
      if (abort_after > 0 && k == abort_after) begin
        do_reset(3);
        break;
      end
      if (k > 200) begin
        check_eq("frame_timeout", 32'(k), 0);
        break;
      end
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    n_cmp = 0; n_err = 0; cyc = 0;
    model_clear();
    @(negedge clk);
    do_reset(5);
    idle_steps(3);

    run_frame(0, 1'b0, 0);     // gapless, data 0..15
    idle_steps(2);
    run_frame(1, 1'b0, 0);     // every 3rd cycle a bubble
    idle_steps(3);
    run_frame(2, 1'b1, 0);     // start held high throughout: must be ignored
    run_frame(0, 1'b0, 0);     // back-to-back: start in the cycle IDLE returns
    run_frame(2, 1'b0, 0);     // back-to-back again
    idle_steps(2);
    run_frame(2, 1'b0, 7);     // reset mid-RUN
    idle_steps(2);
    run_frame(0, 1'b0, 0);     // full frame after abort
    for (int f = 0; f < 5; f++) begin
      run_frame(2, 1'($urandom_range(0, 1)), 0);
      idle_steps($urandom_range(0, 3));
    end
    idle_steps(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
